uart_rx_cfg: RTL
================

# uart_rx_cfg

Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver. It adds:
- configurable data width, parity mode and stop-bit count;
- a 2-flop input synchroniser and 3-sample majority voting;
- parity, framing and overrun error reporting;
- a one-deep valid/ready output register, so a downstream consumer can stall.

It sits between the FPGA RX pin and the byte-stream logic that feeds the network input loader.

## Interface
- CLK_PER_BIT, 5208: clock cycles per bit (clk_frequency / baud_rate); legal range 8..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  gates start-bit detection only.
- rx  in  1  asynchronous serial line, idle high.
- data_out  out  DATA_BITS  received word, LSB received first.
- valid  out  1  data_out holds an unconsumed word.
- ready  in  1  consumer accepts the word when valid && ready.
- parity_err  out  1  qualifies data_out: parity mismatch.
- frame_err  out  1  qualifies data_out: at least one stop bit sampled low.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.

## Operation
- **Input synchroniser.** rx passes through two flops to give rx_s. Both flops reset to 1.
- **Half period.** HALF = (CLK_PER_BIT-1)/2. A 16-bit counter cnt times each bit.
- **Majority vote.** Each bit's value is the majority of three rx_s samples.
  - Start bit: samples at cnt = HALF-2, HALF-1, HALF.
  - All other bits: samples at cnt = CLK_PER_BIT-3, -2, -1.
- **States:** IDLE, START, DATA, PAR, STOP.
  - IDLE: cnt = 0 and bit index = 0. The block arms once rx_s has been seen high. When armed, rx_s == 0 and enable == 1, go to START.
  - START: at cnt == HALF:
    - vote 1: glitch, go to IDLE;
    - vote 0: cnt <= 0, go to DATA.
  - DATA: at cnt == CLK_PER_BIT-1, store the vote into shift[index] and set cnt <= 0. After DATA_BITS bits, go to PAR if PARITY != 0, otherwise go to STOP.
  - PAR: sample one bit.
    - Odd parity: the data bits plus the parity bit must contain an odd number of ones.
    - Even parity: the same count must be even.
    - A mismatch sets the pending parity error.
  - STOP: sample STOP_BITS bits. Any stop bit voted 0 sets the pending frame error. After the last stop bit, the frame completes and the block goes to IDLE.
- **Frame errors.** A frame with frame_err is still delivered. After a frame error, IDLE stays disarmed until rx_s returns high, so a line break does not retrigger reception.
- **enable.** Deasserting enable mid-frame does not abort the frame.
- **Completion with the output register free.** The output register is free when valid == 0, or when valid && ready in the completion cycle. On that edge:
  - data_out, parity_err and frame_err are loaded;
  - valid becomes 1.
- **Completion with the output register full.** The output register is full when valid && !ready. Then:
  - the new frame is discarded;
  - the old word and its flags are held unchanged;
  - overrun is high for exactly one cycle.
- **Handshake.** On valid && ready with no simultaneous completion, valid drops on the next edge. data_out and the error flags are don't-care while valid == 0, but hold their last values.
- **Reset.**
  - rst is sampled every edge and overrides everything, including mid-frame reception.
  - Resulting values: state IDLE and disarmed, cnt = 0, index = 0.
  - Outputs: data_out = 0, valid = 0, parity_err = 0, frame_err = 0, overrun = 0.

## Timing
- **Definitions.** E0 is the first clk edge at which the synchroniser's first flop captures rx = 0. PB = 1 if PARITY != 0, otherwise 0.
- **Latency.** valid rises at edge E0 + 3 + HALF + (DATA_BITS + PB + STOP_BITS) * CLK_PER_BIT.
- **Back-to-back frames.** The next start bit is accepted from the first edge after the block returns to IDLE. Back-to-back frames with zero idle time between them must be received without loss.
- **Clock tolerance.** The block tolerates ±4 % baud mismatch between the transmitter and CLK_PER_BIT.

## Structure
- **Package uart_pkg** holds:
  - the state enum;
  - parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the function parity_of(word).
- The future uart_tx_cfg reuses this package.
- **Sub-module uart_rx_sync_vote** contains the 2-flop synchroniser and the 3-sample majority shift register. It exposes rx_s and vote.

## Test plan
All tests use CLK_PER_BIT = 16 unless stated otherwise.
- 8N1 frame 0xA5 with ready tied high: data_out = 0xA5, valid high for 1 cycle, all flags 0, and valid rises exactly at the Timing formula edge.
- 7E2 frame 0x3C with the parity bit flipped: data_out = 0x3C with parity_err = 1. The same frame sent correctly gives parity_err = 0.
- 8N1 frame 0x55 with the stop bit held low for 3 bit times: frame_err = 1. No new start is detected until rx returns high.
- Two back-to-back frames 0x11 then 0x22 with ready = 0:
  - 0x11 is held;
  - overrun pulses one cycle at the second frame's completion;
  - raising ready then yields 0x11 and valid drops.
- Start glitch (rx low for 3 cycles) produces no valid. Single-cycle inverted spikes inside data bits do not corrupt 0xC3 (majority vote).
- rst asserted mid-DATA of frame 0xFF: all outputs are 0 on the next edge. A following clean 0x0F frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the configurable UART blocks.
//   uart_state_e   receive FSM states
//   PAR_NONE/ODD/EVEN  parity mode encodings for the PARITY parameter
//   parity_of()    XOR reduction of a data word (up to 9 bits, zero-extended)
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } uart_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // 1 when the word holds an odd number of ones.
   function automatic logic parity_of(input logic [8:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// uart_rx_sync_vote: 2-flop synchroniser for the asynchronous rx pin plus
// a 3-sample majority voter over the synchronised line.
//   clk, rst  system clock, synchronous active-high reset
//   rx        asynchronous serial input, idle high
//   rx_s      synchronised line
//   vote      majority of rx_s in this cycle and the two previous cycles
module uart_rx_sync_vote (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s,
   output logic vote
);

   logic       meta_q;
   logic       sync_q;
   logic [1:0] hist_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         hist_q <= 2'b11;
      end else begin
         meta_q <= rx;
         sync_q <= meta_q;
         hist_q <= {hist_q[0], sync_q};
      end
   end

   assign rx_s = sync_q;

   // The current rx_s is the third sample, so the vote decided at count N
   // covers the samples at N-2, N-1 and N.
   assign vote = (hist_q[1] & hist_q[0]) |
                 (hist_q[1] & sync_q)    |
                 (hist_q[0] & sync_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with a one-deep valid/ready output register.
//   clk, rst    system clock, synchronous active-high reset
//   enable      gates start-bit detection only
//   rx          asynchronous serial line, idle high
//   data_out    received word, LSB first on the line
//   valid       data_out holds an unconsumed word
//   ready       consumer takes the word when valid && ready
//   parity_err  parity mismatch for the word in data_out
//   frame_err   a stop bit of the word in data_out was sampled low
//   overrun     one-cycle pulse: a completed frame was dropped
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 5208,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam logic [15:0] HALF = 16'((CLK_PER_BIT - 1) / 2);
   localparam logic [15:0] LAST = 16'(CLK_PER_BIT - 1);

   logic rx_s;
   logic vote;

   uart_rx_sync_vote u_sync_vote (
      .clk  (clk),
      .rst  (rst),
      .rx   (rx),
      .rx_s (rx_s),
      .vote (vote)
   );

   uart_state_e          state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 armed_q, armed_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 valid_q, valid_d;
   logic                 perr_out_q, perr_out_d;
   logic                 ferr_out_q, ferr_out_d;
   logic                 overrun_q, overrun_d;

   logic                 bit_end;
   logic                 complete;
   logic                 ferr_now;

   assign bit_end  = (cnt_q == LAST);
   // Frame error including the stop bit being decided this cycle.
   assign ferr_now = ferr_q | ~vote;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         armed_q    <= 1'b0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         armed_q    <= armed_d;
         dout_q     <= dout_d;
         valid_q    <= valid_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
         overrun_q  <= overrun_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (armed_q && !rx_s && enable) state_d = ST_START;
         ST_START: if (cnt_q == HALF) state_d = vote ? ST_IDLE : ST_DATA;
         ST_DATA:  if (bit_end && idx_q == 4'(DATA_BITS - 1))
                      state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
         ST_PAR:   if (bit_end) state_d = ST_STOP;
         ST_STOP:  if (bit_end && idx_q == 4'(STOP_BITS - 1)) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- datapath / output logic ----------------
   always_comb begin
      cnt_d    = cnt_q + 16'd1;
      idx_d    = idx_q;
      shift_d  = shift_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            idx_d  = '0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
         end
         ST_START: begin
            if (cnt_q == HALF) cnt_d = '0;
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               for (int i = 0; i < DATA_BITS; i++) begin
                  if (idx_q == 4'(i)) shift_d[i] = vote;
               end
               idx_d = (idx_q == 4'(DATA_BITS - 1)) ? 4'd0 : idx_q + 4'd1;
            end
         end
         ST_PAR: begin
            if (bit_end) begin
               cnt_d = '0;
               // Data plus parity XOR is 1 for an odd count of ones.
               if ((parity_of(9'(shift_q)) ^ vote) != (PARITY == PAR_ODD))
                  perr_d = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               cnt_d  = '0;
               ferr_d = ferr_now;
               if (idx_q == 4'(STOP_BITS - 1)) begin
                  idx_d    = '0;
                  complete = 1'b1;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: begin
            cnt_d = '0;
            idx_d = '0;
         end
      endcase

      // A frame ending in a framing error leaves the receiver disarmed so a
      // held-low line (break) cannot start a new frame; seeing high re-arms.
      armed_d = rx_s | (armed_q & ~(complete & ferr_now));

      dout_d     = dout_q;
      valid_d    = valid_q;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      overrun_d  = complete & valid_q & ~ready;
      if (complete && (!valid_q || ready)) begin
         dout_d     = shift_q;
         perr_out_d = perr_q;
         ferr_out_d = ferr_now;
         valid_d    = 1'b1;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   assign data_out   = dout_q;
   assign valid      = valid_q;
   assign parity_err = perr_out_q;
   assign frame_err  = ferr_out_q;
   assign overrun    = overrun_q;

endmodule
